// File: rtl/emitter_arbiter.sv
// emitter_arbiter: round-robin share of one serial output_emitter among
// NUM_REQ parallel-word producers. The word of the winning requester is
// captured, presented with a one-cycle load strobe, and the requester is
// acknowledged once the emitter reports serial completion.
// Optional watchdog: define EMITTER_ARB_TIMEOUT_EN to abandon a transfer whose
// completion never arrives within TIMEOUT_CYCLES wait cycles.
module emitter_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OUTPUT_WIDTH   = 25,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            fast_clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*OUTPUT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              ack,
  output logic [OUTPUT_WIDTH-1:0]         em_data,
  output logic                            em_ready,
  input  logic                            em_serial_done,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] cur, last, win;
  logic          any_req;
  logic          expired;

  // Round-robin pick: scan from last+1 upward (cyclic); descending loop so the
  // nearest candidate after last is the one that sticks.
  always_comb begin
    int t;
    win     = '0;
    any_req = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      t = int'(last) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      if (req[t]) win = IW'(t);
    end
  end

`ifdef EMITTER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // Wait-cycle counter: cleared while issuing, advances in both wait states.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset)                                    cnt <= '0;
    else if (state == ISSUE)                      cnt <= '0;
    else if (state == WAIT_LO || state == WAIT_HI) cnt <= cnt + 1'b1;
  end

  // Limit is reached on the wait cycle whose edge brings cnt to TIMEOUT_CYCLES.
  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Sticky error: set whenever a wait state falls straight back to IDLE.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) timeout_err <= 1'b0;
    else if ((state == WAIT_LO || state == WAIT_HI) && state_n == IDLE)
      timeout_err <= 1'b1;
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state logic; a completion seen in WAIT_HI beats an expiring watchdog.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   state_n = WAIT_LO;
      WAIT_LO: if (!em_serial_done) state_n = WAIT_HI;
               else if (expired)    state_n = IDLE;
      WAIT_HI: if (em_serial_done)  state_n = RELEASE;
               else if (expired)    state_n = IDLE;
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, capture of the winner's word/index, and round-robin pointer.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cur     <= '0;
      last    <= IW'(NUM_REQ - 1);
      em_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        cur     <= win;
        em_data <= req_data[win*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
      if (state != IDLE && state_n == IDLE) last <= cur;
    end
  end

  // Outputs decode directly from state so reset clears them immediately.
  always_comb begin
    busy     = (state != IDLE);
    em_ready = (state == ISSUE);
    grant    = busy ? (NUM_REQ'(1) << cur) : '0;
    ack      = (state == RELEASE) ? (NUM_REQ'(1) << cur) : '0;
  end

endmodule
